// File: rtl/utm_stepper_pkg.sv
// rtl/utm_stepper_pkg.sv - shared types and constants for the Turing-machine stepper
//   UTM_SYM_W / UTM_STATE_W : symbol and state widths of the rule-entry type
//   fsm_t                   : stepper FSM states
//   rule_t                  : rule-table entry {next_state, new_sym, dir}
//   DIR_LEFT / DIR_RIGHT    : head-move encodings of rule_t.dir
package utm_stepper_pkg;

   localparam int UTM_SYM_W   = 3;
   localparam int UTM_STATE_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_DONE
   } fsm_t;

   typedef struct packed {
      logic [UTM_STATE_W-1:0] next_state;
      logic [UTM_SYM_W-1:0]   new_sym;
      logic                   dir;
   } rule_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/utm_rule_table.sv
// rtl/utm_rule_table.sv - programmable rule table, sync write / comb read
//   clk   : clock
//   we    : write enable for one entry
//   waddr : write index {state, symbol}
//   wdata : entry {next_state, new_sym, dir}
//   raddr : read index {state, symbol}
//   rdata : combinational read of entry[raddr]
// Contents are not reset; entries are undefined until written.
module utm_rule_table
   import utm_stepper_pkg::*;
#(
   parameter int IDX_W = UTM_STATE_W + UTM_SYM_W,
   parameter int DW    = UTM_STATE_W + UTM_SYM_W + 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [DW-1:0]    wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [DW-1:0]    rdata
);

   logic [DW-1:0] mem [2**IDX_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/utm_stepper.sv
// rtl/utm_stepper.sv - sequential Turing-machine stepper with on-chip tape
//   clk, rst_n        : clock, synchronous active-low reset
//   cfg_we/addr/data  : host rule write {state,sym} <- {next_state,new_sym,dir}
//   tape_we/addr/wdata: host tape write; tape_rdata is a comb read of tape[tape_addr]
//   start             : one-cycle pulse starting a run (ignored while busy)
//   busy/halted/fault : run status; state_out/head_out/steps : machine state
// Build option UTM_TAPE_WRAP_EN: head wraps modulo TAPE_LEN instead of faulting.
// SYM_W/STATE_W must match the widths of rule_t in utm_stepper_pkg.
module utm_stepper
   import utm_stepper_pkg::*;
#(
   parameter int                 SYM_W      = UTM_SYM_W,
   parameter int                 STATE_W    = UTM_STATE_W,
   parameter int                 TAPE_LEN   = 16,
   parameter logic [STATE_W-1:0] HALT_STATE = '1,
   parameter int                 CNT_W      = 16,
   localparam int                AW         = $clog2(TAPE_LEN)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cfg_we,
   input  logic [STATE_W+SYM_W-1:0]   cfg_addr,
   input  logic [STATE_W+SYM_W:0]     cfg_data,
   input  logic                       tape_we,
   input  logic [AW-1:0]              tape_addr,
   input  logic [SYM_W-1:0]           tape_wdata,
   output logic [SYM_W-1:0]           tape_rdata,
   input  logic                       start,
   output logic                       busy,
   output logic                       halted,
   output logic                       fault,
   output logic [STATE_W-1:0]         state_out,
   output logic [AW-1:0]              head_out,
   output logic [CNT_W-1:0]           steps
);

   fsm_t                     fsm;
   rule_t                    rule_q;
   logic [STATE_W+SYM_W:0]   rule_rd;
   logic [SYM_W-1:0]         tape [TAPE_LEN];
   logic [SYM_W-1:0]         head_sym;
   logic [AW-1:0]            head_next;
   logic                     host_ok;

   // Host access only outside a run; reset also blocks writes on its edge.
   assign host_ok  = rst_n && ((fsm == ST_IDLE) || (fsm == ST_DONE));
   assign head_sym = tape[head_out];

   utm_rule_table #(
      .IDX_W (STATE_W + SYM_W),
      .DW    (STATE_W + SYM_W + 1)
   ) u_rule_table (
      .clk   (clk),
      .we    (cfg_we && host_ok),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr ({state_out, head_sym}),
      .rdata (rule_rd)
   );

   // Power-of-two tape: AW-bit arithmetic wraps naturally.
   always_comb begin
      head_next = (rule_q.dir == DIR_RIGHT) ? head_out + AW'(1) : head_out - AW'(1);
   end

`ifndef UTM_TAPE_WRAP_EN
   logic off_tape;
   assign off_tape = (rule_q.dir == DIR_LEFT)  ? (head_out == '0)
                                               : (head_out == AW'(TAPE_LEN - 1));
`endif

   // Tape storage is not reset so host data survives a mid-run reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (fsm == ST_EXEC) begin
            tape[head_out] <= rule_q.new_sym;
         end else if (host_ok && tape_we) begin
            tape[tape_addr] <= tape_wdata;
         end
      end
   end

   assign tape_rdata = tape[tape_addr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm       <= ST_IDLE;
         busy      <= 1'b0;
         halted    <= 1'b0;
         fault     <= 1'b0;
         state_out <= '0;
         head_out  <= '0;
         steps     <= '0;
         rule_q    <= '0;
      end else begin
         case (fsm)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  fsm       <= ST_FETCH;
                  busy      <= 1'b1;
                  halted    <= 1'b0;
                  fault     <= 1'b0;
                  state_out <= '0;
                  head_out  <= '0;
                  steps     <= '0;
               end
            end
            ST_FETCH: begin
               if (state_out == HALT_STATE) begin
                  halted <= 1'b1;
                  busy   <= 1'b0;
                  fsm    <= ST_DONE;
               end else begin
                  rule_q <= rule_t'(rule_rd);
                  fsm    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               state_out <= rule_q.next_state;
               if (steps != '1) begin
                  steps <= steps + CNT_W'(1);
               end
`ifdef UTM_TAPE_WRAP_EN
               head_out <= head_next;
               fsm      <= ST_FETCH;
`else
               if (off_tape) begin
                  fault <= 1'b1;
                  busy  <= 1'b0;
                  fsm   <= ST_DONE;
               end else begin
                  head_out <= head_next;
                  fsm      <= ST_FETCH;
               end
`endif
            end
            default: fsm <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_utm_stepper.sv
// tb/tb_utm_stepper.sv - directed self-checking bench for utm_stepper
module tb_utm_stepper;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_we;
   logic [5:0] cfg_addr;
   logic [6:0] cfg_data;
   logic       tape_we;
   logic [3:0] tape_addr;
   logic [2:0] tape_wdata;
   logic [2:0] tape_rdata;
   logic       start;
   logic       busy, halted, fault;
   logic [2:0] state_out;
   logic [3:0] head_out;
   logic [15:0] steps;

   int n_cmp = 0;
   int n_bad = 0;

   utm_stepper dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .tape_we    (tape_we),
      .tape_addr  (tape_addr),
      .tape_wdata (tape_wdata),
      .tape_rdata (tape_rdata),
      .start      (start),
      .busy       (busy),
      .halted     (halted),
      .fault      (fault),
      .state_out  (state_out),
      .head_out   (head_out),
      .steps      (steps)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_rule(input int st, input int sym, input int ns, input int nsym, input int dir);
      cfg_we   = 1'b1;
      cfg_addr = {3'(st), 3'(sym)};
      cfg_data = {3'(ns), 3'(nsym), 1'(dir)};
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic wr_tape(input int a, input int d);
      tape_we    = 1'b1;
      tape_addr  = 4'(a);
      tape_wdata = 3'(d);
      tick();
      tape_we    = 1'b0;
   endtask

   task automatic clear_tape();
      for (int i = 0; i < 16; i++) wr_tape(i, 0);
   endtask

   task automatic rd_tape(input int a, output logic [2:0] d);
      tape_addr = 4'(a);
      #1;
      d = tape_rdata;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      while (busy && n < max_cyc) begin
         tick();
         n++;
      end
      if (busy) check("run_timeout", 32'(busy), 0);
   endtask

   task automatic load_increment();
      wr_rule(0, 1, 0, 0, 1);
      wr_rule(0, 0, 7, 1, 1);
      clear_tape();
      wr_tape(0, 1);
      wr_tape(1, 1);
   endtask

   logic [2:0] d;

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      tape_we = 1'b0; tape_addr = '0; tape_wdata = '0; start = 1'b0;
      tick();
      tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_state", 32'(state_out), 0);
      check("rst_head", 32'(head_out), 0);
      check("rst_steps", 32'(steps), 0);
      check("rst_halted", 32'(halted), 0);
      check("rst_fault", 32'(fault), 0);
      rst_n = 1'b1;

      // Immediate halt: one transition, busy falls at t+4.
      clear_tape();
      wr_rule(0, 0, 7, 0, 1);
      pulse_start();                       // edge t+1
      check("ih_busy_t1", 32'(busy), 1);
      tick(); tick();                      // t+3
      check("ih_busy_t3", 32'(busy), 1);
      tick();                              // t+4
      check("ih_busy_t4", 32'(busy), 0);
      check("ih_halted", 32'(halted), 1);
      check("ih_steps", 32'(steps), 1);
      check("ih_head", 32'(head_out), 1);
      check("ih_state", 32'(state_out), 7);
      rd_tape(0, d);
      check("ih_tape0", 32'(d), 0);

      // Binary increment 3 -> 4: three transitions, busy falls at t+8.
      load_increment();
      pulse_start();
      for (int i = 0; i < 6; i++) tick(); // t+7
      check("inc_busy_t7", 32'(busy), 1);
      tick();                              // t+8
      check("inc_busy_t8", 32'(busy), 0);
      check("inc_halted", 32'(halted), 1);
      check("inc_steps", 32'(steps), 3);
      check("inc_head", 32'(head_out), 3);
      rd_tape(0, d); check("inc_tape0", 32'(d), 0);
      rd_tape(1, d); check("inc_tape1", 32'(d), 0);
      rd_tape(2, d); check("inc_tape2", 32'(d), 1);

      // Left move off cell 0.
      clear_tape();
      wr_tape(0, 2);
      wr_rule(0, 2, 1, 5, 0);
`ifdef UTM_TAPE_WRAP_EN
      wr_rule(1, 0, 7, 0, 1);
      pulse_start();                       // t+1
      tick(); tick();                      // t+3: first EXEC done
      check("wrap_head15", 32'(head_out), 15);
      check("wrap_busy", 32'(busy), 1);
      wait_idle(20);
      check("wrap_head0", 32'(head_out), 0);
      check("wrap_halted", 32'(halted), 1);
      check("wrap_fault", 32'(fault), 0);
      check("wrap_steps", 32'(steps), 2);
      rd_tape(0, d); check("wrap_tape0", 32'(d), 5);
      rd_tape(15, d); check("wrap_tape15", 32'(d), 0);
`else
      pulse_start();
      wait_idle(20);
      check("off_fault", 32'(fault), 1);
      check("off_halted", 32'(halted), 0);
      check("off_state", 32'(state_out), 1);
      check("off_head", 32'(head_out), 0);
      check("off_steps", 32'(steps), 1);
      rd_tape(0, d); check("off_tape0", 32'(d), 5);
`endif

      // Writes and start while busy are ignored.
      load_increment();
      pulse_start();                       // t+1
      tick();                              // t+2
      tape_we = 1'b1; tape_addr = 4'd3; tape_wdata = 3'd6;
      cfg_we = 1'b1; cfg_addr = {3'd0, 3'd0}; cfg_data = {3'd7, 3'd2, 1'b1};
      start = 1'b1;
      tick();                              // t+3
      tape_we = 1'b0; cfg_we = 1'b0; start = 1'b0;
      tick(); tick(); tick(); tick();      // t+7
      check("wb_busy_t7", 32'(busy), 1);
      tick();                              // t+8
      check("wb_busy_t8", 32'(busy), 0);
      check("wb_steps", 32'(steps), 3);
      rd_tape(3, d); check("wb_tape3", 32'(d), 0);
      rd_tape(2, d); check("wb_tape2", 32'(d), 1);

      // The same writes in DONE take effect.
      wr_tape(3, 6);
      rd_tape(3, d); check("done_tape3", 32'(d), 6);
      wr_rule(0, 0, 7, 2, 1);
      wr_tape(0, 1); wr_tape(1, 1); wr_tape(2, 0);
      pulse_start();
      wait_idle(20);
      rd_tape(2, d); check("done_rule_tape2", 32'(d), 2);
      check("done_rule_steps", 32'(steps), 3);

      // Reset mid-run: outputs clear, already-written tape cells remain.
      load_increment();
      pulse_start();                       // t+1
      tick(); tick();                      // t+3: tape[0] <- 0
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mr_busy", 32'(busy), 0);
      check("mr_state", 32'(state_out), 0);
      check("mr_head", 32'(head_out), 0);
      check("mr_steps", 32'(steps), 0);
      check("mr_halted", 32'(halted), 0);
      check("mr_fault", 32'(fault), 0);
      rd_tape(0, d); check("mr_tape0", 32'(d), 0);
      rd_tape(1, d); check("mr_tape1", 32'(d), 1);

      // Reset together with start wins.
      rst_n = 1'b0; start = 1'b1;
      tick();
      rst_n = 1'b1; start = 1'b0;
      check("rs_busy", 32'(busy), 0);
      tick();
      check("rs_busy2", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
